// File: rtl/e4m3_add_scheduler.sv
// Operand/result buffering around an external pipelined e4m3 adder.
// Credit-based issue reserves a result slot for every pair sent into the adder.
module e4m3_add_scheduler #(
  parameter int IN_DEPTH    = 4,
  parameter int RES_DEPTH   = 4,
  parameter int ADD_LATENCY = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  input  logic [7:0] add_y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_y,
  output logic       busy
);

  localparam int IW = $clog2(IN_DEPTH);
  localparam int RW = $clog2(RES_DEPTH);
  localparam int OW = $clog2(ADD_LATENCY + RES_DEPTH + 1);
  localparam logic [IW:0] IN_FULL = (IW + 1)'(IN_DEPTH);
  localparam logic [OW-1:0] RES_LIM = OW'(RES_DEPTH);

  logic [7:0]       in_a_mem_r [IN_DEPTH];
  logic [7:0]       in_b_mem_r [IN_DEPTH];
  logic [IW-1:0]    in_wptr_r;
  logic [IW-1:0]    in_rptr_r;
  logic [IW:0]      in_count_r;

  logic [ADD_LATENCY-1:0] pipe_r;
  logic [7:0]       add_a_r;
  logic [7:0]       add_b_r;

  logic [7:0]       res_mem_r [RES_DEPTH];
  logic [RW-1:0]    res_wptr_r;
  logic [RW-1:0]    res_rptr_r;
  logic [RW:0]      res_count_r;

  logic             accept_s;
  logic             issue_s;
  logic             capture_s;
  logic             pop_s;
  logic [OW-1:0]    outstanding_s;

  // Handshake and credit decode from registered state only.
  always_comb begin
    outstanding_s = OW'(res_count_r);
    for (int i = 0; i < ADD_LATENCY; i++) begin
      outstanding_s = outstanding_s + OW'(pipe_r[i]);
    end
    in_ready  = (in_count_r != IN_FULL);
    out_valid = (res_count_r != (RW + 1)'(0));
    out_y     = res_mem_r[res_rptr_r];
    accept_s  = in_valid & in_ready;
    issue_s   = (in_count_r != (IW + 1)'(0)) & (outstanding_s < RES_LIM);
    capture_s = pipe_r[ADD_LATENCY-1];
    pop_s     = out_valid & out_ready;
    busy      = (in_count_r != (IW + 1)'(0)) | (|pipe_r) | (res_count_r != (RW + 1)'(0));
    add_a     = add_a_r;
    add_b     = add_b_r;
  end

  // Operand FIFO storage and pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < IN_DEPTH; i++) begin
        in_a_mem_r[i] <= 8'h00;
        in_b_mem_r[i] <= 8'h00;
      end
      in_wptr_r <= IW'(0);
      in_rptr_r <= IW'(0);
    end else begin
      if (accept_s) begin
        in_a_mem_r[in_wptr_r] <= in_a;
        in_b_mem_r[in_wptr_r] <= in_b;
        in_wptr_r             <= in_wptr_r + IW'(1);
      end
      if (issue_s) begin
        in_rptr_r <= in_rptr_r + IW'(1);
      end
    end
  end

  // Operand FIFO occupancy, net of same-edge accept and issue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_count_r <= (IW + 1)'(0);
    end else begin
      case ({accept_s, issue_s})
        2'b10:   in_count_r <= in_count_r + (IW + 1)'(1);
        2'b01:   in_count_r <= in_count_r - (IW + 1)'(1);
        default: in_count_r <= in_count_r;
      endcase
    end
  end

  // Adder operand registers hold the last issued pair while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      add_a_r <= 8'h00;
      add_b_r <= 8'h00;
    end else if (issue_s) begin
      add_a_r <= in_a_mem_r[in_rptr_r];
      add_b_r <= in_b_mem_r[in_rptr_r];
    end else begin
      add_a_r <= add_a_r;
      add_b_r <= add_b_r;
    end
  end

  // Valid pipe tracking which adder stages carry an issued pair.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_r <= '0;
    end else begin
      pipe_r[0] <= issue_s;
      for (int i = 1; i < ADD_LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  // Result FIFO storage and pointers; credits guarantee a free slot on capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RES_DEPTH; i++) begin
        res_mem_r[i] <= 8'h00;
      end
      res_wptr_r <= RW'(0);
      res_rptr_r <= RW'(0);
    end else begin
      if (capture_s) begin
        res_mem_r[res_wptr_r] <= add_y;
        res_wptr_r            <= res_wptr_r + RW'(1);
      end
      if (pop_s) begin
        res_rptr_r <= res_rptr_r + RW'(1);
      end
    end
  end

  // Result FIFO occupancy, net of same-edge capture and pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_count_r <= (RW + 1)'(0);
    end else begin
      case ({capture_s, pop_s})
        2'b10:   res_count_r <= res_count_r + (RW + 1)'(1);
        2'b01:   res_count_r <= res_count_r - (RW + 1)'(1);
        default: res_count_r <= res_count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_e4m3_add_scheduler.sv
// Bench for e4m3_add_scheduler with a one-register behavioural e4m3 adder
// (two-edge latency) and a queue-based scoreboard of expected sums.
module tb_e4m3_add_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic [7:0] add_y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         pop_cyc[$];
  logic [7:0] pa[8];
  logic [7:0] pb[8];

  e4m3_add_scheduler dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_y(add_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) begin
      for (int i = 0; i < n; i++) r = r * 2.0;
    end else begin
      for (int i = 0; i < -n; i++) r = r / 2.0;
    end
    return r;
  endfunction

  function automatic real e4m3_val(input logic [7:0] c);
    real v;
    int  e;
    int  m;
    e = int'(c[6:3]);
    m = int'(c[2:0]);
    if (e == 0) v = (real'(m) / 8.0) * pow2(-6);
    else        v = (1.0 + real'(m) / 8.0) * pow2(e - 7);
    return c[7] ? -v : v;
  endfunction

  // Exact real sum, rounded to the nearest finite e4m3 code (ties to even, saturating).
  function automatic logic [7:0] e4m3_add(input logic [7:0] a, input logic [7:0] b);
    real s, mag, d, bestd;
    logic [7:0] best, cc;
    if (a[6:0] == 7'h7F || b[6:0] == 7'h7F) return 8'h7F;
    s     = e4m3_val(a) + e4m3_val(b);
    mag   = (s < 0.0) ? -s : s;
    best  = 8'h00;
    bestd = mag;
    for (int c = 1; c < 127; c++) begin
      cc = 8'(c);
      d  = mag - e4m3_val(cc);
      if (d < 0.0) d = -d;
      if (d < bestd || (d == bestd && best[0] == 1'b1)) begin
        best  = cc;
        bestd = d;
      end
    end
    if (s < 0.0 && best != 8'h00) best[7] = 1'b1;
    return best;
  endfunction

  always @(posedge clock) add_y <= e4m3_add(add_a, add_b);

  // Advance one cycle, logging accepted pairs and popped results seen before the edge.
  task automatic tick;
    @(negedge clock);
    if (in_valid && in_ready) exp_q.push_back(e4m3_add(in_a, in_b));
    if (out_valid && out_ready) begin
      got_q.push_back(out_y);
      pop_cyc.push_back(cyc);
    end
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic clear_logs;
    exp_q.delete();
    got_q.delete();
    pop_cyc.delete();
  endtask

  task automatic gen_pairs;
    logic [7:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom);
      a[6:4] = 3'(i);
      if (a[6:0] == 7'h7F) a[0] = 1'b0;
      b = 8'($urandom);
      if (b[6:0] == 7'h7F) b[0] = 1'b0;
      pa[i] = a;
      pb[i] = b;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = 8'h00; in_b = 8'h00;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_y !== 8'h00) begin errors++; $display("FAIL reset_out_y got %h exp 00", out_y); end
    checks++; if (add_a !== 8'h00 || add_b !== 8'h00) begin errors++; $display("FAIL reset_add_ab got %h/%h exp 00/00", add_a, add_b); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    #1 reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_single;
    int lat;
    clear_logs();
    out_ready = 1'b1; in_valid = 1'b1; in_a = 8'h40; in_b = 8'h40;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    checks++; if (lat !== 3) begin errors++; $display("FAIL single_latency got %0d exp 3", lat); end
    checks++; if (out_y !== 8'h48) begin errors++; $display("FAIL single_out_y got %h exp 48", out_y); end
    tick();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_idle_after_pop busy %b out_valid %b exp 0 0", busy, out_valid); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL single_count got %0d exp 1", got_q.size()); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] va[3], vb[3], vy[3];
    int n;
    clear_logs();
    va[0] = 8'h40; vb[0] = 8'h40; vy[0] = 8'h48;
    va[1] = 8'h28; vb[1] = 8'h10; vy[1] = 8'h29;
    va[2] = 8'h50; vb[2] = 8'h10; vy[2] = 8'h50;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i];
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (got_q.size() < 3 && n < 30) begin tick(); n++; end
    checks++;
    if (got_q.size() !== 3) begin
      errors++; $display("FAIL b2b_count got %0d exp 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (got_q[i] !== vy[i]) begin errors++; $display("FAIL b2b_value[%0d] got %h exp %h", i, got_q[i], vy[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++; if (pop_cyc[i] !== pop_cyc[i-1] + 1) begin errors++; $display("FAIL b2b_consecutive[%0d] got cycle %0d exp %0d", i, pop_cyc[i], pop_cyc[i-1] + 1); end
      end
    end
  endtask

  task automatic test_backpressure;
    int idx, n;
    logic acc;
    clear_logs();
    gen_pairs();
    out_ready = 1'b0;
    idx = 0; n = 0;
    while (idx < 8 && n < 50) begin
      in_valid = 1'b1; in_a = pa[idx]; in_b = pb[idx];
      acc = in_ready;
      tick();
      if (acc) idx++;
      n++;
    end
    in_valid = 1'b0;
    checks++; if (idx !== 8) begin errors++; $display("FAIL bp_accepted got %0d exp 8", idx); end
    repeat (4) tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL bp_valid_busy got %b %b exp 1 1", out_valid, busy); end
    checks++; if (add_a !== pa[3] || add_b !== pb[3]) begin errors++; $display("FAIL bp_last_issued got %h/%h exp %h/%h", add_a, add_b, pa[3], pb[3]); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL bp_no_pop got %0d exp 0", got_q.size()); end
  endtask

  task automatic test_hold_while_full;
    logic [7:0] ha, hb;
    logic acc, took;
    int n;
    ha = 8'h38; hb = 8'h30;
    in_valid = 1'b1; in_a = ha; in_b = hb;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d] got %b exp 0", i, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    took = 1'b0; n = 0;
    while (!took && n < 30) begin
      acc = in_ready;
      tick();
      if (acc) took = 1'b1;
      n++;
    end
    in_valid = 1'b0;
    checks++; if (took !== 1'b1) begin errors++; $display("FAIL hold_accept got %b exp 1", took); end
    n = 0;
    while (got_q.size() < 9 && n < 60) begin tick(); n++; end
    repeat (10) tick();
    checks++;
    if (got_q.size() !== 9 || exp_q.size() !== 9) begin
      errors++; $display("FAIL hold_total got %0d exp 9 (model %0d)", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (got_q[i] !== e4m3_add(pa[i], pb[i])) begin errors++; $display("FAIL bp_order[%0d] got %h exp %h", i, got_q[i], e4m3_add(pa[i], pb[i])); end
      end
      checks++; if (got_q[8] !== e4m3_add(ha, hb)) begin errors++; $display("FAIL hold_value got %h exp %h", got_q[8], e4m3_add(ha, hb)); end
    end
  endtask

  task automatic test_toggle;
    int idx;
    logic hold, acc;
    logic [7:0] hv;
    clear_logs();
    gen_pairs();
    idx = 0;
    for (int t = 0; t < 200 && got_q.size() < 6; t++) begin
      in_valid = (idx < 6);
      if (idx < 6) begin in_a = pa[idx]; in_b = pb[idx]; end
      out_ready = t[0];
      hold = out_valid && !out_ready;
      hv   = out_y;
      acc  = in_valid && in_ready;
      tick();
      if (acc) idx++;
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_y !== hv) begin errors++; $display("FAIL toggle_stable got %b/%h exp 1/%h", out_valid, out_y, hv); end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got_q.size() !== 6) begin
      errors++; $display("FAIL toggle_count got %0d exp 6", got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (got_q[i] !== e4m3_add(pa[i], pb[i])) begin errors++; $display("FAIL toggle_order[%0d] got %h exp %h", i, got_q[i], e4m3_add(pa[i], pb[i])); end
      end
    end
  endtask

  task automatic test_reset_inflight;
    logic saw;
    int n;
    clear_logs();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h40; in_b = 8'h38; tick();
    in_a = 8'h48; in_b = 8'h40; tick();
    in_valid = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_y !== 8'h00) begin errors++; $display("FAIL rst_fly_out got %b/%h exp 0/00", out_valid, out_y); end
    checks++; if (add_a !== 8'h00 || add_b !== 8'h00) begin errors++; $display("FAIL rst_fly_add got %h/%h exp 00/00", add_a, add_b); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_fly_flags busy %b in_ready %b exp 0 1", busy, in_ready); end
    #2 reset = 1'b0;
    clear_logs();
    saw = 1'b0;
    repeat (8) begin tick(); if (out_valid) saw = 1'b1; end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL rst_fly_no_valid got %b exp 0", saw); end
    in_valid = 1'b1; in_a = 8'h30; in_b = 8'h30; tick();
    in_valid = 1'b0;
    n = 0;
    while (got_q.size() < 1 && n < 20) begin tick(); n++; end
    repeat (3) tick();
    checks++;
    if (got_q.size() !== 1) begin
      errors++; $display("FAIL rst_fly_new_count got %0d exp 1", got_q.size());
    end else begin
      checks++; if (got_q[0] !== 8'h38) begin errors++; $display("FAIL rst_fly_new_value got %h exp 38", got_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_hold_while_full();
    test_toggle();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
